// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared types and constants for the multi-cycle MIPS control path:
//   - FSM state encoding
//   - instruction class produced by mips_instr_classify
//   - PC source and register-destination selects
//   - the state-only output bundle and its decode function
//   Optional build macro that other files react to: MULDIV_STALL_EN.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALTED
  } state_t;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_J, CLS_JAL, CLS_JR, CLS_JALR, CLS_MULDIV, CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2
  } reg_dst_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [2:0] OPG_LOAD  = 3'b100;
  localparam logic [2:0] OPG_STORE = 3'b101;
  localparam logic [2:0] OPG_IALU  = 3'b001;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;
  localparam logic [3:0] FN_MULDIV = 4'b0110;  // funct[5:2]: mult/multu/div/divu

  // Outputs that depend only on state and instruction class. They are
  // computed for the next state and registered, so they are glitch-free.
  typedef struct packed {
    logic     active;
    logic     mem_read;
    logic     mem_write;
    pc_src_t  pc_src;
    logic     alu_src;
    reg_dst_t reg_dst;
    logic     reg_write;
    logic     mem_to_reg;
  } moore_t;

  function automatic moore_t moore_out(input state_t s, input instr_class_t c);
    moore_t o;
    o = '{active: 1'b1, mem_read: 1'b0, mem_write: 1'b0, pc_src: PC_PLUS4,
          alu_src: 1'b0, reg_dst: DST_RT, reg_write: 1'b0, mem_to_reg: 1'b0};
    case (s)
      FETCH: o.mem_read = 1'b1;
      EXEC: begin
        case (c)
          CLS_IALU, CLS_LOAD, CLS_STORE: o.alu_src = 1'b1;
          CLS_BRANCH: o.pc_src = PC_BRANCH;
          CLS_J:      o.pc_src = PC_JUMP;
          CLS_JAL: begin
            o.pc_src    = PC_JUMP;
            o.reg_write = 1'b1;
            o.reg_dst   = DST_RA;
          end
          CLS_JR:     o.pc_src = PC_RS;
          // The link write is state-driven, so it is issued even when the
          // jump target turns out to be zero and the core halts.
          CLS_JALR: begin
            o.pc_src    = PC_RS;
            o.reg_write = 1'b1;
            o.reg_dst   = DST_RD;
          end
          default: ;
        endcase
      end
      MEM: begin
        o.mem_read  = (c == CLS_LOAD);
        o.mem_write = (c == CLS_STORE);
      end
      WB: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = (c == CLS_RALU) ? DST_RD : DST_RT;
        o.mem_to_reg = (c == CLS_LOAD);
      end
      HALTED: o.active = 1'b0;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_fsm_if.sv
// mips_mc_ctrl_fsm_if
//   Control-path bundle between the multi-cycle FSM and the datapath/memory.
//   master: the controller (drives strobes, samples status)
//   slave : the datapath/memory side
//   Inputs to the controller : instr, mem_ready, branch_taken, jr_target_zero
//                              (+ muldiv_done with MULDIV_STALL_EN)
//   Outputs of the controller: mem_read, mem_write, ir_write, pc_write, pc_src,
//                              alu_src, reg_dst, reg_write, mem_to_reg, active,
//                              timeout_err (+ muldiv_start with MULDIV_STALL_EN)
interface mips_mc_ctrl_fsm_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        jr_target_zero;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic        mem_to_reg;
  logic        active;
  logic        timeout_err;
`ifdef MULDIV_STALL_EN
  logic        muldiv_start;
  logic        muldiv_done;

  modport master (
    input  instr, mem_ready, branch_taken, jr_target_zero, muldiv_done,
    output mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
           reg_dst, reg_write, mem_to_reg, active, timeout_err, muldiv_start
  );
  modport slave (
    output instr, mem_ready, branch_taken, jr_target_zero, muldiv_done,
    input  mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
           reg_dst, reg_write, mem_to_reg, active, timeout_err, muldiv_start
  );
`else
  modport master (
    input  instr, mem_ready, branch_taken, jr_target_zero,
    output mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
           reg_dst, reg_write, mem_to_reg, active, timeout_err
  );
  modport slave (
    output instr, mem_ready, branch_taken, jr_target_zero,
    input  mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
           reg_dst, reg_write, mem_to_reg, active, timeout_err
  );
`endif
endinterface

// File: rtl/mips_instr_classify.sv
// mips_instr_classify
//   Combinational instruction classifier, shared with future hazard logic.
//   instr_i : 32-bit instruction word
//   cls_o   : instruction class
//   R-type functs other than JR/JALR/mul-div are all treated as ALU ops.
module mips_instr_classify
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  instr_i,
  output instr_class_t cls_o
);
  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (op == OP_RTYPE) begin
      if (fn == FN_JR)                cls_o = CLS_JR;
      else if (fn == FN_JALR)         cls_o = CLS_JALR;
      else if (fn[5:2] == FN_MULDIV)  cls_o = CLS_MULDIV;
      else                            cls_o = CLS_RALU;
    end else if (op[5:3] == OPG_LOAD)  cls_o = CLS_LOAD;
    else if (op[5:3] == OPG_STORE)     cls_o = CLS_STORE;
    else if (op[5:3] == OPG_IALU)      cls_o = CLS_IALU;
    else if (op == OP_BEQ || op == OP_BNE || op == OP_BLEZ ||
             op == OP_BGTZ || op == OP_REGIMM)
      cls_o = CLS_BRANCH;
    else if (op == OP_J)               cls_o = CLS_J;
    else if (op == OP_JAL)             cls_o = CLS_JAL;
  end
endmodule

// File: rtl/mips_mc_ctrl_fsm.sv
// mips_mc_ctrl_fsm
//   Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   Waits on mem_ready for fetch and load/store, halts on a stalled memory
//   access (sticky timeout_err) or on JR/JALR to address zero.
//   clk, reset : clock, synchronous active-high reset (all outputs 0 while high)
//   bus        : mips_mc_ctrl_fsm_if.master control bundle
//   MEM_TIMEOUT: max wait cycles for a memory access (>= 2)
//   Build macro MULDIV_STALL_EN: adds muldiv_start/muldiv_done and holds EXEC
//   for mul/div until done; without it mul/div is a one-cycle EXEC no-op.
module mips_mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  mips_mc_ctrl_fsm_if.master bus
);
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic         terr_q;
  moore_t       out_q;
  instr_class_t cls;
  logic         waiting, tmo_hit, exec_pcw, fetch_done;
`ifdef MULDIV_STALL_EN
  logic         mds_q;
`endif

  mips_instr_classify u_cls (
    .instr_i (bus.instr),
    .cls_o   (cls)
  );

  // Memory is busy in FETCH and in MEM (MEM only ever holds loads/stores).
  assign waiting    = (state_q == FETCH || state_q == MEM) && !bus.mem_ready;
  assign tmo_hit    = waiting && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign fetch_done = (state_q == FETCH) && bus.mem_ready;

  always_comb begin
    exec_pcw = 1'b0;
    case (cls)
      CLS_BRANCH:        exec_pcw = bus.branch_taken;
      CLS_J, CLS_JAL:    exec_pcw = 1'b1;
      CLS_JR, CLS_JALR:  exec_pcw = !bus.jr_target_zero;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready)  state_d = DECODE;
        else if (tmo_hit)   state_d = HALTED;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (cls)
          CLS_RALU, CLS_IALU:  state_d = WB;
          CLS_LOAD, CLS_STORE: state_d = MEM;
          CLS_JR, CLS_JALR:    state_d = bus.jr_target_zero ? HALTED : FETCH;
`ifdef MULDIV_STALL_EN
          CLS_MULDIV:          state_d = bus.muldiv_done ? FETCH : EXEC;
`endif
          default:             state_d = FETCH;
        endcase
      end
      MEM: begin
        if (bus.mem_ready)  state_d = (cls == CLS_LOAD) ? WB : FETCH;
        else if (tmo_hit)   state_d = HALTED;
      end
      WB:      state_d = FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  // Counter runs only while the same access keeps waiting; any state change
  // (completion, halt) clears it.
  assign tmo_d = (waiting && state_d == state_q) ? tmo_q + TMO_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      tmo_q   <= '0;
      terr_q  <= 1'b0;
      out_q   <= moore_out(FETCH, CLS_ILLEGAL);
`ifdef MULDIV_STALL_EN
      mds_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (tmo_hit) terr_q <= 1'b1;
      out_q   <= moore_out(state_d, cls);
`ifdef MULDIV_STALL_EN
      // One-cycle start pulse on the first EXEC cycle only.
      mds_q   <= (state_q == DECODE) && (cls == CLS_MULDIV);
`endif
    end
  end

  // Reset gates every output combinationally so an in-flight access drops
  // in the same cycle reset is raised.
  assign bus.active      = out_q.active     & ~reset;
  assign bus.mem_read    = out_q.mem_read   & ~reset;
  assign bus.mem_write   = out_q.mem_write  & ~reset;
  assign bus.pc_src      = reset ? 2'd0 : out_q.pc_src;
  assign bus.alu_src     = out_q.alu_src    & ~reset;
  assign bus.reg_dst     = reset ? 2'd0 : out_q.reg_dst;
  assign bus.reg_write   = out_q.reg_write  & ~reset;
  assign bus.mem_to_reg  = out_q.mem_to_reg & ~reset;
  assign bus.timeout_err = terr_q           & ~reset;
  assign bus.ir_write    = fetch_done & ~reset;
  assign bus.pc_write    = (fetch_done || (state_q == EXEC && exec_pcw)) && !reset;
`ifdef MULDIV_STALL_EN
  assign bus.muldiv_start = mds_q & ~reset;
`endif
endmodule

// File: tb/tb_mips_mc_ctrl_fsm.sv
module tb_mips_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mc_ctrl_fsm_if bus();

  mips_mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {active, timeout_err, mem_read, mem_write, ir_write, pc_write,
  //  pc_src[1:0], alu_src, reg_dst[1:0], reg_write, mem_to_reg}
  localparam logic [12:0] NONE = 13'h0000, ACT = 13'h1000, TERR = 13'h0800,
    MRD = 13'h0400, MWR = 13'h0200, IRW = 13'h0100, PCW = 13'h0080,
    PCS1 = 13'h0020, PCS2 = 13'h0040, PCS3 = 13'h0060, ALUS = 13'h0010,
    RD1 = 13'h0004, RD2 = 13'h0008, RGW = 13'h0002, M2R = 13'h0001;
  localparam logic [12:0] FETCHED = ACT | MRD | IRW | PCW;

  localparam logic [31:0] I_ADDU = 32'h00221821, I_LW = 32'h8CA40008,
    I_SW = 32'hACA40008, I_BEQ = 32'h10220004, I_J = 32'h08000010,
    I_JAL = 32'h0C000010, I_JALR = 32'h0020F809, I_ADDIU = 32'h24010005,
    I_ILL = 32'hFC000000, I_MULT = 32'h00220018, I_JR0 = 32'h00000008;

  typedef struct {
    string       nm;
    logic [12:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] cur_ins = 32'h0;
  bit          done = 1'b0;

  initial begin
    bus.instr = 32'h0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jr_target_zero = 1'b0;
`ifdef MULDIV_STALL_EN
    bus.muldiv_done = 1'b1;
`endif
  end

  // Monitor: compares one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [12:0] got;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = {bus.active, bus.timeout_err, bus.mem_read, bus.mem_write,
             bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src,
             bus.reg_dst, bus.reg_write, bus.mem_to_reg};
      nvec++;
      if (got !== e.v) begin
        nerr++;
        $display("FAIL %s: got %013b expected %013b", e.nm, got, e.v);
      end
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic rdy,
                     input logic bt, input logic jz, input logic [12:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst;
    bus.instr = cur_ins;
    bus.mem_ready = rdy;
    bus.branch_taken = bt;
    bus.jr_target_zero = jz;
    x.nm = nm;
    x.v = e;
    sbq.push_back(x);
  endtask

  task automatic fetch(input logic [31:0] ins);
    cur_ins = ins;
    cyc("fetch", 1'b0, 1'b1, 1'b0, 1'b0, FETCHED);
    cyc("decode", 1'b0, 1'b1, 1'b0, 1'b0, ACT);
  endtask

  initial begin
    cyc("reset0", 1'b1, 1'b1, 1'b1, 1'b1, NONE);
    cyc("reset1", 1'b1, 1'b1, 1'b1, 1'b1, NONE);

    fetch(I_ADDU);
    cyc("addu_exec", 0, 1, 0, 0, ACT);
    cyc("addu_wb",   0, 1, 0, 0, ACT | RGW | RD1);

    fetch(I_LW);
    cyc("lw_exec", 0, 1, 0, 0, ACT | ALUS);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 0, 0, 0, 0, ACT | MRD);
    cyc("lw_mem_rdy", 0, 1, 0, 0, ACT | MRD);
    cyc("lw_wb",      0, 1, 0, 0, ACT | RGW | M2R);

    fetch(I_SW);
    cyc("sw_exec", 0, 1, 0, 0, ACT | ALUS);
    cyc("sw_mem",  0, 1, 0, 0, ACT | MWR);

    fetch(I_BEQ);
    cyc("beq_taken", 0, 1, 1, 0, ACT | PCW | PCS1);
    fetch(I_BEQ);
    cyc("beq_not", 0, 1, 0, 0, ACT | PCS1);

    fetch(I_J);
    cyc("j_exec", 0, 1, 0, 0, ACT | PCW | PCS2);
    fetch(I_JAL);
    cyc("jal_exec", 0, 1, 0, 0, ACT | PCW | PCS2 | RGW | RD2);
    fetch(I_JALR);
    cyc("jalr_exec", 0, 1, 0, 0, ACT | PCW | PCS3 | RGW | RD1);

    fetch(I_ADDIU);
    cyc("addiu_exec", 0, 1, 0, 0, ACT | ALUS);
    cyc("addiu_wb",   0, 1, 0, 0, ACT | RGW);

    fetch(I_ILL);
    cyc("illegal_exec", 0, 1, 1, 1, ACT);
`ifndef MULDIV_STALL_EN
    fetch(I_MULT);
    cyc("mult_exec", 0, 1, 0, 0, ACT);
`endif

    // Reset raised while a store waits in MEM.
    fetch(I_SW);
    cyc("sw2_exec", 0, 1, 0, 0, ACT | ALUS);
    cyc("sw2_mem",  0, 0, 0, 0, ACT | MWR);
    cyc("sw2_rst",  1, 0, 0, 0, NONE);

    // Late fetch, ready on the 4th waiting cycle: no timeout.
    cur_ins = I_ADDU;
    for (int i = 0; i < 3; i++) cyc("fetch_late", 0, 0, 0, 0, ACT | MRD);
    cyc("fetch_late_rdy", 0, 1, 0, 0, FETCHED);
    cyc("late_decode", 0, 1, 0, 0, ACT);
    cyc("late_exec",   0, 1, 0, 0, ACT);
    cyc("late_wb",     0, 1, 0, 0, ACT | RGW | RD1);

    // jr $0 halts without a PC write.
    fetch(I_JR0);
    cyc("jr0_exec", 0, 1, 0, 1, ACT | PCS3);
    for (int i = 0; i < 3; i++) cyc("halted", 0, 1, 1, 0, NONE);
    cyc("halt_rst", 1, 1, 0, 0, NONE);

    // Fetch never completes: error on the edge ending the 4th wait.
    for (int i = 0; i < 4; i++) cyc("tmo_wait", 0, 0, 0, 0, ACT | MRD);
    cyc("tmo_err0", 0, 1, 0, 0, TERR);
    cyc("tmo_err1", 0, 1, 0, 0, TERR);
    cyc("tmo_rst",  1, 1, 0, 0, NONE);
    cyc("tmo_after", 0, 1, 0, 0, FETCHED);

    @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
    end
  end
endmodule
